// File: rtl/monta_senha_pkg.sv
// ============================================================================
// Module      : monta_senha_pkg
// Description : Shared types and constants for the keypad password collector
//               (packed password word, key codes, FSM states, buffer ops).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package monta_senha_pkg;

  // Digit slots carried in one password word.
  localparam int N_DIGITS = 20;

  // Width of the held-digit counter (0..N_DIGITS).
  localparam int N_W = $clog2(N_DIGITS + 1);

  // Filler value for an unused digit slot.
  localparam logic [3:0] DIGIT_VAZIO = 4'hF;

  // Keypad control codes.
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  // Password word: digits[0] is the first typed digit, at bits [3:0].
  typedef struct packed {
    logic [N_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  // Collector FSM states; the fourth encoding is unreachable.
  typedef enum logic [1:0] {
    COLETANDO  = 2'd0,
    ENVIANDO   = 2'd1,
    AGUARDANDO = 2'd2
  } monta_estado_t;

  // Commands from the FSM to the digit buffer.
  typedef enum logic [1:0] {
    BUF_NOP   = 2'd0,
    BUF_PUSH  = 2'd1,
    BUF_CLEAR = 2'd2
  } buf_op_t;

  // True for a numeric key code 0x0..0x9.
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'd9);
  endfunction

endpackage : monta_senha_pkg

`default_nettype wire

// File: rtl/monta_senha_shift_buffer.sv
// ============================================================================
// Module      : shift_buffer_senha
// Description : N_DIGITS x 4-bit password register file. PUSH appends a digit
//               while space remains and slides the window (oldest dropped)
//               once full; CLEAR refills every slot with DIGIT_VAZIO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_buffer_senha
  import monta_senha_pkg::*;
#(
  parameter int N_DIGITS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  buf_op_t                  op,
  input  logic [3:0]               digit,
  output logic [N_DIGITS-1:0][3:0] slots,
  output logic [N_W-1:0]           n_digits
);

  logic [N_DIGITS-1:0][3:0] r_slots;
  logic [N_DIGITS-1:0][3:0] w_slots;
  logic [N_W-1:0]           r_n;
  logic [N_W-1:0]           w_n;

  // Next buffer contents for the requested operation.
  always_comb begin
    w_slots = r_slots;
    w_n     = r_n;
    case (op)
      BUF_PUSH: begin
        if (r_n < N_W'(N_DIGITS)) begin
          w_slots[r_n] = digit;
          w_n          = r_n + N_W'(1);
        end else begin
          // Full: slide the window so the newest digits stay searchable.
          for (int i = 0; i < N_DIGITS - 1; i++) begin
            w_slots[i] = r_slots[i+1];
          end
          w_slots[N_DIGITS-1] = digit;
        end
      end
      BUF_CLEAR: begin
        w_slots = {N_DIGITS{DIGIT_VAZIO}};
        w_n     = '0;
      end
      default: ;
    endcase
  end

  // Buffer register; reset leaves every slot empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slots <= {N_DIGITS{DIGIT_VAZIO}};
      r_n     <= '0;
    end else begin
      r_slots <= w_slots;
      r_n     <= w_n;
    end
  end

  assign slots    = r_slots;
  assign n_digits = r_n;

endmodule : shift_buffer_senha

`default_nettype wire

// File: rtl/monta_senha.sv
// ============================================================================
// Module      : monta_senha
// Description : Keypad-side collector. Assembles typed digits into a
//               senhaPac_t, pulses valid_out to verifica_senha on ENTER,
//               holds the word frozen until done_in, then clears.
//               Optional idle timeout: define MONTA_SENHA_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module monta_senha
  import monta_senha_pkg::*;
#(
  parameter int N_DIGITS       = 20,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            digit_valid,
  input  logic [3:0]      digit,
  input  logic            done_in,
  output senhaPac_t       senha_teste,
  output logic            valid_out,
  output logic            busy,
  output logic [N_W-1:0]  n_digits
);

  // The slot count must agree with the packed word shared with the verifier.
  if (N_DIGITS != monta_senha_pkg::N_DIGITS || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("monta_senha: N_DIGITS must match the package and TIMEOUT_CYCLES must be >= 2");
  end

  monta_estado_t r_state;
  monta_estado_t w_state_next;
  buf_op_t       w_op;
  logic          r_valid_out;
  logic          r_busy;
  logic          w_has_digits;
  logic          w_key_digit;
  logic          w_key_clear;
  logic          w_key_enter;
  logic          w_expire;

  assign w_has_digits = (n_digits != '0);
  assign w_key_digit  = digit_valid && is_digit(digit);
  assign w_key_clear  = digit_valid && (digit == KEY_CLEAR);
  assign w_key_enter  = digit_valid && (digit == KEY_ENTER);

`ifdef MONTA_SENHA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             w_key_accept;

  assign w_key_accept = w_key_digit || w_key_clear || w_key_enter;
  assign w_expire     = (r_state == COLETANDO) && w_has_digits &&
                        (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only on a partial entry, restarts on any key or expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state != COLETANDO) || !w_has_digits || w_key_accept || w_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= COLETANDO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and buffer command; a key always wins over a timeout clear.
  always_comb begin
    w_state_next = r_state;
    w_op         = BUF_NOP;
    case (r_state)
      COLETANDO: begin
        if (w_key_digit) begin
          w_op = BUF_PUSH;
        end else if (w_key_clear) begin
          w_op = BUF_CLEAR;
        end else if (w_key_enter && w_has_digits) begin
          w_state_next = ENVIANDO;
        end else if (w_expire) begin
          w_op = BUF_CLEAR;
        end
      end
      ENVIANDO: begin
        w_state_next = AGUARDANDO;
      end
      AGUARDANDO: begin
        // Keys in the done_in cycle are dropped; the word stays frozen until now.
        if (done_in) begin
          w_op         = BUF_CLEAR;
          w_state_next = COLETANDO;
        end
      end
      default: begin
        w_op         = BUF_CLEAR;
        w_state_next = COLETANDO;
      end
    endcase
  end

  // Registered handshake outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid_out <= (w_state_next == ENVIANDO);
      r_busy      <= (w_state_next != COLETANDO);
    end
  end

  shift_buffer_senha #(
    .N_DIGITS (N_DIGITS)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .op       (w_op),
    .digit    (digit),
    .slots    (senha_teste.digits),
    .n_digits (n_digits)
  );

  assign valid_out = r_valid_out;
  assign busy      = r_busy;

endmodule : monta_senha

`default_nettype wire

// File: tb/tb_monta_senha.sv
// ============================================================================
// Module      : tb_monta_senha
// Description : Self-checking bench for monta_senha: directed scenarios plus
//               randomized keys against a queue-based reference model.
//               Timeout scenarios are built with MONTA_SENHA_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_monta_senha;
  import monta_senha_pkg::*;

  localparam int TO = 8;
  localparam logic [79:0] ALL_F = {20{4'hF}};

  logic            clk;
  logic            rst;
  logic            digit_valid;
  logic [3:0]      digit;
  logic            done_in;
  senhaPac_t       senha_teste;
  logic            valid_out;
  logic            busy;
  logic [N_W-1:0]  n_digits;

  int n_vec;
  int n_err;

  // Reference model: typed digits in order, plus a coarse phase.
  int q[$];
  int m_phase;   // 0 collecting, 1 submitting, 2 waiting for done
  int m_idle;

  monta_senha #(
    .N_DIGITS       (20),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .done_in     (done_in),
    .senha_teste (senha_teste),
    .valid_out   (valid_out),
    .busy        (busy),
    .n_digits    (n_digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] model_word();
    logic [79:0] w;
    w = ALL_F;
    for (int i = 0; i < q.size(); i++) begin
      w[i*4 +: 4] = 4'(q[i]);
    end
    return w;
  endfunction

  task automatic model_reset();
    q.delete();
    m_phase = 0;
    m_idle  = 0;
  endtask

  task automatic model_edge(input logic dv, input logic [3:0] d, input logic dn);
    bit taken;
    taken = 0;
    case (m_phase)
      0: begin
        if (dv && d <= 4'd9) begin
          q.push_back(int'(d));
          if (q.size() > 20) void'(q.pop_front());
          taken = 1;
        end else if (dv && d == KEY_CLEAR) begin
          q.delete();
          taken = 1;
        end else if (dv && d == KEY_ENTER && q.size() > 0) begin
          m_phase = 1;
          taken   = 1;
        end
`ifdef MONTA_SENHA_TIMEOUT_EN
        if (m_phase != 0 || taken || q.size() == 0) m_idle = 0;
        else if (m_idle == TO - 1) begin
          q.delete();
          m_idle = 0;
        end else m_idle++;
`endif
      end
      1: m_phase = 2;
      default: if (dn) begin
        q.delete();
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_senha"}, senha_teste, model_word());
    check({tag, "_n"},     80'(n_digits), 80'(q.size()));
    check({tag, "_valid"}, 80'(valid_out), 80'(m_phase == 1));
    check({tag, "_busy"},  80'(busy), 80'(m_phase != 0));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic dv, input logic [3:0] d, input logic dn);
    digit_valid = dv;
    digit       = d;
    done_in     = dn;
    @(posedge clk);
    model_edge(dv, d, dn);
    #1;
    compare_model("step");
    digit_valid = 1'b0;
    done_in     = 1'b0;
  endtask

  initial begin
    logic [3:0] d;
    logic       dv;
    logic       dn;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    digit_valid = 1'b0;
    digit = 4'h0;
    done_in = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_senha", senha_teste, ALL_F);
    check("rst_n",     80'(n_digits), 80'd0);
    check("rst_valid", 80'(valid_out), 80'd0);
    check("rst_busy",  80'(busy), 80'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1,2,3,4,ENTER then wait for done.
    step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd3, 0); step(1, 4'd4, 0);
    check("t1_pre_valid", 80'(valid_out), 80'd0);
    step(1, KEY_ENTER, 0);
    check("t1_valid", 80'(valid_out), 80'd1);
    check("t1_word",  senha_teste, {{16{4'hF}}, 16'h4321});
    step(0, 4'd0, 0);
    check("t1_valid_drop", 80'(valid_out), 80'd0);
    check("t1_busy", 80'(busy), 80'd1);
    step(1, 4'd9, 0);
    step(1, KEY_ENTER, 0);
    check("t2_frozen", senha_teste, {{16{4'hF}}, 16'h4321});
    check("t2_busy", 80'(busy), 80'd1);
    step(1, 4'd5, 1);
    check("t2_clear", senha_teste, ALL_F);
    check("t2_n", 80'(n_digits), 80'd0);
    check("t2_busy_lo", 80'(busy), 80'd0);

    // 22 keys of i mod 10: window keeps the newest 20.
    for (int i = 0; i < 22; i++) step(1, 4'(i % 10), 0);
    check("t3_n", 80'(n_digits), 80'd20);
    check("t3_d0",  80'(senha_teste.digits[0]), 80'd2);
    check("t3_d19", 80'(senha_teste.digits[19]), 80'd1);
    step(1, KEY_CLEAR, 0);

    // 5,6,CLEAR,ENTER: nothing submitted.
    step(1, 4'd5, 0); step(1, 4'd6, 0); step(1, KEY_CLEAR, 0); step(1, KEY_ENTER, 0);
    step(0, 4'd0, 0);
    check("t4_word", senha_teste, ALL_F);
    check("t4_valid", 80'(valid_out), 80'd0);
    check("t4_busy", 80'(busy), 80'd0);

`ifdef MONTA_SENHA_TIMEOUT_EN
    step(1, 4'd7, 0);
    repeat (7) step(0, 4'd0, 0);
    check("to_hold", 80'(n_digits), 80'd1);
    step(0, 4'd0, 0);
    check("to_clear", senha_teste, ALL_F);
    check("to_n", 80'(n_digits), 80'd0);
    step(1, 4'd7, 0);
    repeat (5) step(0, 4'd0, 0);
    step(1, 4'd8, 0);
    check("to_keep", 80'(n_digits), 80'd2);
    step(1, KEY_CLEAR, 0);
`endif

    // Randomized traffic; early part avoids CLEAR/ENTER to exercise the window.
    for (int k = 0; k < 600; k++) begin
      dv = ($urandom_range(0, 3) != 0);
      if (k < 200) begin
        d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 9));
      end else begin
        d = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) d = KEY_ENTER;
      end
      dn = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      step(dv, d, dn);
    end

    // Asynchronous reset while waiting for done.
    step(1, KEY_CLEAR, 0);
    step(1, 4'd3, 0); step(1, KEY_ENTER, 0); step(0, 4'd0, 0);
    check("ar_busy_pre", 80'(busy), 80'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("ar_senha", senha_teste, ALL_F);
    check("ar_n",     80'(n_digits), 80'd0);
    check("ar_valid", 80'(valid_out), 80'd0);
    check("ar_busy",  80'(busy), 80'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 4'd6, 0);
    step(1, KEY_ENTER, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_monta_senha

`default_nettype wire
